aes_decrypt_ctrl: RTL and testbench

AES_DECRYPT_CTRL -- requirements
Module: aes_decrypt_ctrl

---
 rtl/aes_decrypt_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_aes_decrypt_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES inverse cipher: one shared decryptRound reused per cycle, round keys from keyExpansion.
// Optional macro AES_DEC_ABORT_EN adds an abort input that cancels a block in flight.

package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+4-rw)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// Full key schedule; w[0] lands in the top word so the last round key sits at fullkeys_o[127:0].
module keyExpansion #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]       key_i,
  output logic [128*(Nr+1)-1:0]  fullkeys_o
);
  import aes_dec_pkg::*;

  localparam int unsigned NW = 4 * (Nr + 1);

  function automatic logic [128*(Nr+1)-1:0] expand(input logic [32*Nk-1:0] k);
    logic [31:0]            w [NW];
    logic [31:0]            t;
    logic [7:0]             rc;
    logic [128*(Nr+1)-1:0]  r;
    rc = 8'h01;
    r  = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = k[32*(Nk-1-i) +: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
      r[32*(NW-1-i) +: 32] = w[i];
    end
    return r;
  endfunction

  assign fullkeys_o = expand(key_i);
endmodule

module decryptRound (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);
  import aes_dec_pkg::*;

  assign state_o = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state_i)) ^ key_i);
endmodule

module aes_decrypt_ctrl #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in,
  input  logic [N-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out,
  output logic           busy
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic           abort
`endif
);
  import aes_dec_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] RND_LAST = 4'(Nr);
  localparam logic [3:0] RND_PRE  = 4'(Nr - 1);

  state_e                 state_q, state_d;
  logic [3:0]             rnd_q, rnd_d;
  logic [127:0]           st_q, st_d;
  logic [127:0]           out_q, out_d;
  logic [N-1:0]           key_q, key_d;
  logic [128*(Nr+1)-1:0]  fullkeys;
  logic [127:0]           rk [Nr+1];
  logic [127:0]           st_eff, round_out, final_out;

  keyExpansion #(.Nk(Nk), .Nr(Nr)) u_key_exp (
    .key_i      (key_q),
    .fullkeys_o (fullkeys)
  );

  for (genvar k = 0; k <= Nr; k++) begin : g_rk
    assign rk[k] = fullkeys[k*128 +: 128];
  end

  // Schedule only sees key_q, so rk(0) is not ready at accept: st holds raw
  // ciphertext and the initial AddRoundKey is folded into the rnd==1 step.
  assign st_eff    = (rnd_q == 4'd1) ? (st_q ^ rk[0]) : st_q;
  assign final_out = inv_sub_bytes(inv_shift_rows(st_eff)) ^ rk[Nr];

  decryptRound u_round (
    .state_i (st_eff),
    .key_i   (rk[rnd_q]),
    .state_o (round_out)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ROUND);
  assign out       = out_q;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    key_d   = key_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d   = key;
          st_d    = in;
          rnd_d   = 4'd1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
`ifdef AES_DEC_ABORT_EN
        if (abort) begin
          rnd_d   = '0;
          state_d = S_IDLE;
        end else
`endif
        if (rnd_q != 4'd0 && rnd_q <= RND_PRE) begin
          st_d  = round_out;
          rnd_d = rnd_q + 4'd1;
        end else if (rnd_q == RND_LAST) begin
          out_d   = final_out;
          rnd_d   = '0;
          state_d = S_DONE;
        end else begin
          rnd_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        rnd_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      key_q   <= key_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed bench for aes_decrypt_ctrl using FIPS-197 vectors; abort cases need AES_DEC_ABORT_EN.
module tb_aes_decrypt_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_KEY  = 128'h0;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] Z_PT   = 128'h0;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] din, dout, dkey;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  aes_decrypt_ctrl #(.N(128), .Nr(10), .Nk(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .key       (dkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .busy      (busy)
`ifdef AES_DEC_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic send(input logic [127:0] k, input logic [127:0] c);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    dkey     = k;
    din      = c;
    in_valid = 1'b1;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic watch_no_valid(input string tag, input int unsigned cycles);
    int unsigned seen;
    seen = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq(tag, 128'(seen), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned  e;
    logic [127:0] v_key [3];
    logic [127:0] v_ct  [3];
    logic [127:0] v_pt  [3];
    int unsigned  tout  [3];
    int unsigned  nsent, nout, cyc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    dkey      = '0;
`ifdef AES_DEC_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready",  128'(in_ready),  128'(1));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_busy",      128'(busy),      128'(0));
    check_eq("rst_out",       dout,            128'h0);
    rst = 1'b0;

    // reset wins over a simultaneous accept
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; dkey = C1_KEY; din = C1_CT;
    @(negedge clk);
    check_eq("rstprio_busy",     128'(busy),     128'(0));
    check_eq("rstprio_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0; in_valid = 1'b0;

    // C.1 with latency and backpressure
    send(C1_KEY, C1_CT);
    check_eq("c1_busy", 128'(busy), 128'(1));
    wait_valid(e);
    check_eq("c1_latency", 128'(e), 128'(10));
    check_eq("c1_out", dout, C1_PT);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_out_valid", 128'(out_valid), 128'(1));
      check_eq("bp_in_ready",  128'(in_ready),  128'(0));
      check_eq("bp_out",       dout,            C1_PT);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_in_ready",  128'(in_ready),  128'(1));
    check_eq("bp_release_out_valid", 128'(out_valid), 128'(0));
    out_ready = 1'b0;

    // inputs change right after accept
    send(C1_KEY, C1_CT);
    din  = '1;
    dkey = '1;
    wait_valid(e);
    check_eq("chg_latency", 128'(e), 128'(10));
    check_eq("chg_out", dout, C1_PT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // reset at rnd=5 discards the block
    send(B_KEY, B_CT);
    repeat (4) @(negedge clk);
    check_eq("mid_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_in_ready",  128'(in_ready),  128'(1));
    check_eq("mid_out_valid", 128'(out_valid), 128'(0));
    check_eq("mid_busy_low",  128'(busy),      128'(0));
    check_eq("mid_out_zero",  dout,            128'h0);
    watch_no_valid("mid_no_valid", 12);
    send(C1_KEY, C1_CT);
    wait_valid(e);
    check_eq("post_rst_latency", 128'(e), 128'(10));
    check_eq("post_rst_out", dout, C1_PT);
    out_ready = 1'b1;
    @(negedge clk);

    // back-to-back with in_valid held and out_ready high
    v_key = '{B_KEY, Z_KEY, C1_KEY};
    v_ct  = '{B_CT,  Z_CT,  C1_CT};
    v_pt  = '{B_PT,  Z_PT,  C1_PT};
    tout  = '{default: 0};
    nsent = 0;
    nout  = 0;
    cyc   = 0;
    while (nout < 3 && cyc < 100) begin
      if (out_valid) begin
        check_eq("b2b_out", dout, v_pt[nout]);
        tout[nout] = cyc;
        nout++;
      end
      if (in_ready) begin
        if (nsent < 3) begin
          dkey     = v_key[nsent];
          din      = v_ct[nsent];
          in_valid = 1'b1;
          nsent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("b2b_count", 128'(nout), 128'(3));
    check_eq("b2b_gap01", 128'(tout[1] - tout[0]), 128'(12));
    check_eq("b2b_gap12", 128'(tout[2] - tout[1]), 128'(12));
    @(negedge clk);

`ifdef AES_DEC_ABORT_EN
    // abort at rnd=3 returns to IDLE with out untouched
    out_ready = 1'b0;
    send(B_KEY, B_CT);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_in_ready",  128'(in_ready),  128'(1));
    check_eq("abort_busy",      128'(busy),      128'(0));
    check_eq("abort_out_valid", 128'(out_valid), 128'(0));
    check_eq("abort_out_keep",  dout,            C1_PT);
    watch_no_valid("abort_no_valid", 12);
    // abort held high in DONE has no effect
    send(B_KEY, B_CT);
    wait_valid(e);
    abort = 1'b1;
    @(negedge clk);
    check_eq("abort_done_valid", 128'(out_valid), 128'(1));
    check_eq("abort_done_out",   dout,            B_PT);
    abort = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
